// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } bus_arb_state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesters and the bus arbiter.
interface bus_arbiter_if #(
  parameter int Bus_length = 32
);

  logic [Bus_length-1:0]                   req;
  logic [Bus_length-1:0]                   grant_sel;
  logic                                    grant_valid;
  logic [bus_pkg::idx_w(Bus_length)-1:0]   grant_idx;
  logic                                    timeout;

  modport master (
    input  req,
    output grant_sel,
    output grant_valid,
    output grant_idx,
    output timeout
  );

  modport slave (
    output req,
    input  grant_sel,
    input  grant_valid,
    input  grant_idx,
    input  timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   rr_ptr,
  output logic [N-1:0]          win_onehot,
  output logic [idx_w(N)-1:0]   win_idx,
  output logic                  any
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    // i = N lands back on rr_ptr itself, so the last owner only wins when nobody else asks.
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N);
      if (!any && req[cand]) begin
        any              = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner select for the shared tri-state bus, with one dead cycle between owners.
// Optional grant time limit enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int Bus_length = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam int IDX_W = idx_w(Bus_length);

  if (Bus_length < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("bus_arbiter: Bus_length must be >= 2 and MAX_HOLD >= 1");
  end

  bus_arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [Bus_length-1:0] sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;
  logic                  force_revoke;

  logic [Bus_length-1:0] win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;

  rr_pick #(
    .N (Bus_length)
  ) u_rr_pick (
    .req        (bus.req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (win_any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign force_revoke = (hold_cnt_q == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d == GRANT) begin
      // The first granted cycle counts as 1; a fresh tenure restarts the count.
      hold_cnt_d = (state_q == GRANT) ? hold_cnt_q + 1'b1 : HOLD_W'(1);
    end
  end
`else
  assign force_revoke = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= IDX_W'(Bus_length - 1);
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE, TURN: begin
        if (win_any) begin
          state_d = GRANT;
          owner_d = win_idx;
          sel_d   = win_onehot;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          owner_d = '0;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (!bus.req[owner_q] || force_revoke) begin
          // Release always passes through TURN so two drivers never overlap.
          state_d   = TURN;
          owner_d   = '0;
          sel_d     = '0;
          valid_d   = 1'b0;
          rr_ptr_d  = owner_q;
          timeout_d = force_revoke && bus.req[owner_q];
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = '0;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant_sel   = sel_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = owner_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter (Bus_length=4, MAX_HOLD=4) against a behavioural model.
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  bus_arbiter_if #(.Bus_length(N)) bif ();

  bus_arbiter #(
    .Bus_length (N),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner (-1 = nobody), last released owner, cycles held, timeout pulse.
  int m_owner;
  int m_last;
  int m_hold;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    m_hold    = 0;
    m_timeout = 0;
  endtask

  task automatic model_clock(input logic [N-1:0] r);
    bit limit;
`ifdef BUS_ARB_TIMEOUT_EN
    limit = (m_hold >= MAX_HOLD);
`else
    limit = 0;
`endif
    m_timeout = 0;
    if (m_owner >= 0) begin
      if (r[m_owner] && !limit) begin
        m_hold++;
      end else begin
        m_timeout = r[m_owner] && limit;
        m_last    = m_owner;
        m_owner   = -1;
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && r[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N;
          m_hold  = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] exp_sel;
    exp_sel = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check({tag, ".sel"},     32'(bif.grant_sel),   32'(exp_sel));
    check({tag, ".valid"},   32'(bif.grant_valid), 32'(m_owner >= 0));
    check({tag, ".idx"},     32'(bif.grant_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".timeout"}, 32'(bif.timeout),     32'(m_timeout));
  endtask

  task automatic step(input string tag, input logic [N-1:0] r);
    bif.req = r;
    @(posedge clk);
    model_clock(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    bif.req = '0;
    rst     = 1'b1;
    model_reset();
    #1;
    check_model({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model({tag, ".rel"});
  endtask

  logic [N-1:0] r;
  logic [N-1:0] prev_sel;
  int           rem  [N];
  int           wait_cnt [N];
  int           exp_owner [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst     = 1'b1;
    bif.req = '0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // 1: single requester, held three cycles then dropped.
    step("t1.g0", 4'b0001);
    check("t1.first", 32'(bif.grant_sel), 32'h1);
    step("t1.g1", 4'b0001);
    step("t1.g2", 4'b0001);
    step("t1.turn", 4'b0000);
    check("t1.turn_zero", 32'(bif.grant_sel), 32'h0);
    step("t1.idle", 4'b0000);

    // 2: all requesting; each owner drops for one cycle to rotate.
    do_reset("t2.rst");
    for (int t = 0; t < 5; t++) begin
      step("t2.grant", 4'b1111);
      check("t2.owner", 32'(bif.grant_idx), 32'(exp_owner[t]));
      step("t2.hold", 4'b1111);
      step("t2.drop", 4'b1111 & ~(4'b0001 << bif.grant_idx));
      check("t2.zero", 32'(bif.grant_sel), 32'h0);
    end

    // 3: owner 2 leaves with 1 and 3 pending.
    do_reset("t3.rst");
    step("t3.g2", 4'b0100);
    step("t3.pend", 4'b1110);
    check("t3.ignored", 32'(bif.grant_idx), 32'd2);
    step("t3.turn", 4'b1010);
    step("t3.g3", 4'b1010);
    check("t3.to3", 32'(bif.grant_sel), 32'h8);
    step("t3.turn2", 4'b0010);
    step("t3.g1", 4'b0010);
    check("t3.to1", 32'(bif.grant_sel), 32'h2);

    // 4: asynchronous reset between edges.
    do_reset("t4.rst");
    step("t4.g0", 4'b0001);
    step("t4.h0", 4'b0001);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("t4.async_sel", 32'(bif.grant_sel), 32'h0);
    check_model("t4.async");
    bif.req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t4.g2", 4'b1100);
    check("t4.first2", 32'(bif.grant_sel), 32'h4);

    // 5: stuck requester; timeout build revokes, default build holds.
    do_reset("t5.rst");
    for (int t = 0; t < 8; t++) step("t5.stuck", 4'b0010);
    check("t5.held", 32'(bif.grant_sel), 32'h2);
    for (int t = 0; t < 6; t++) step("t5.shared", 4'b0110);
    step("t5.end0", 4'b0000);
    step("t5.end1", 4'b0000);

    // 6: random traffic; non-owners hold their request until served.
    do_reset("t6.rst");
    r = '0;
    prev_sel = '0;
    for (int k = 0; k < N; k++) begin
      rem[k]      = 0;
      wait_cnt[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (k == m_owner && r[k]) begin
          if (rem[k] == 0) r[k] = 1'b0;
          else rem[k]--;
        end else if (!r[k] && k != m_owner && $urandom_range(0, 3) == 0) begin
          r[k]   = 1'b1;
          rem[k] = $urandom_range(0, 3);
        end
      end
      step("t6.model", r);
      check("t6.onehot0", 32'($onehot0(bif.grant_sel)), 32'd1);
      if (prev_sel != '0 && bif.grant_sel != '0) begin
        check("t6.no_direct_handoff", 32'(bif.grant_sel), 32'(prev_sel));
      end
      if (prev_sel == '0 && bif.grant_sel != '0) begin
        for (int k = 0; k < N; k++) begin
          if (bif.grant_sel[k])  wait_cnt[k] = 0;
          else if (r[k])         wait_cnt[k]++;
          else                   wait_cnt[k] = 0;
          check("t6.starve", 32'(wait_cnt[k] <= N - 1), 32'd1);
        end
      end
      prev_sel = bif.grant_sel;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
